// File: rtl/serial_negator.sv
// Digit-serial two's-complement pass/negate/abs/nabs unit with valid/ready handshakes.
// Each cycle converts DIGIT bits LSB-first using a sticky "seen a one" flag.
module serial_negator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] datain,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             neg_sel;
  logic [DIGIT-1:0] dig_in, dig_out;
  logic [DIGIT:0]   seen_chain;
  logic [WIDTH-1:0] shifted;

  assign dig_in        = opnd_q[DIGIT-1:0];
  assign seen_chain[0] = seen_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign seen_chain[i+1] = seen_chain[i] | dig_in[i];
    assign dig_out[i]      = dig_in[i] ^ (neg_q & seen_chain[i]);
  end

  // Result digits enter from the MSB side so the word is aligned after digit N-1.
  assign shifted = (dout_q >> DIGIT) | (WIDTH'(dig_out) << (WIDTH - DIGIT));

  always_comb begin
    neg_sel = 1'b0;
    case (mode)
      2'b00:   neg_sel = 1'b0;
      2'b01:   neg_sel = 1'b1;
      2'b10:   neg_sel = datain[WIDTH-1];
      default: neg_sel = ~datain[WIDTH-1] & (|datain);
    endcase
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    seen_d  = seen_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          opnd_d  = datain;
          neg_d   = neg_sel;
          seen_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      RUN: begin
        opnd_d = opnd_q >> DIGIT;
        dout_d = shifted;
        seen_d = seen_chain[DIGIT];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          // Negating anything but the most negative value never yields it.
          ovf_d   = neg_q && (shifted == MIN);
          zero_d  = (shifted == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dataout   = dout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
